// File: rtl/count_capture.sv
// count_capture: samples i_count on each rising edge of i_event into a small FWFT FIFO.
// Optional build macro COUNT_CAPTURE_SYNC_EN adds a 2-flop synchronizer on i_event.
module count_capture #(
   parameter int WIDTH            = 10,
   parameter int DEPTH            = 4,
   parameter int CLEAR_ON_CAPTURE = 0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [WIDTH-1:0]       i_count,
   input  logic                   i_event,
   input  logic                   i_ovf_clear,
   output logic                   o_clear,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic             ev_s;
   logic             ev_q;
   logic             edge_det;
   logic             full;
   logic             push;
   logic             pop;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

`ifdef COUNT_CAPTURE_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], i_event};
      end
   end

   assign ev_s = sync_q[1];
`else
   assign ev_s = i_event;
`endif

   // o_valid/i_ready: a word transfers on every cycle where both are high;
   // o_data holds the head word unchanged while o_valid & ~i_ready.
   assign edge_det = ev_s & ~ev_q;
   assign full     = (o_level == LW'(DEPTH));
   assign o_valid  = (o_level != '0);
   assign pop      = o_valid & i_ready;
   assign push     = edge_det & (~full | pop);
   assign o_data   = mem[rd_ptr];

   // Reset gate keeps the counter's clear quiet while this block is held in reset.
   assign o_clear  = (CLEAR_ON_CAPTURE != 0) && edge_det && !i_rst;

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr] <= i_count;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ev_q       <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_level    <= '0;
         o_overflow <= 1'b0;
      end else begin
         ev_q <= ev_s;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   o_level <= o_level + LW'(1);
            2'b01:   o_level <= o_level - LW'(1);
            default: o_level <= o_level;
         endcase
         // A drop in the same cycle as a clear request leaves the flag set.
         if (edge_det && full && !pop) begin
            o_overflow <= 1'b1;
         end else if (i_ovf_clear) begin
            o_overflow <= 1'b0;
         end
      end
   end

endmodule
